// File: rtl/csr_access_sequencer_pkg.sv
// Shared definitions for the CSR access sequencer: op encodings, trap CSR
// addresses, FSM states and the pipeline legality rule.
package csr_access_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_SET   = 2'd0,
    OP_WRITE = 2'd1,
    OP_CLEAR = 2'd2,
    OP_RSVD  = 2'd3
  } csr_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_RESP
  } state_e;

  typedef enum logic {
    OWN_PIPE,
    OWN_TRAP
  } owner_e;

  localparam logic [11:0] ADDR_MEPC   = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE = 12'h342;
  localparam logic [11:0] ADDR_MTVAL  = 12'h343;
  localparam logic [11:0] ADDR_MTVEC  = 12'h305;
  localparam logic [1:0]  RO_PREFIX   = 2'b11;

  // Read-only CSRs accept only a set-bits access with a zero operand (a pure read).
  function automatic logic pipe_illegal(input logic [1:0] op, input logic [1:0] prefix,
                                        input logic wdata_nz);
    return (op == OP_RSVD) || ((prefix == RO_PREFIX) && ((op != OP_SET) || wdata_nz));
  endfunction

endpackage

// File: rtl/csr_access_sequencer.sv
// CSR front-end: arbitrates pipeline and trap-unit accesses and sequences the
// trap-entry writes (MEPC, MCAUSE, MTVAL) followed by the MTVEC read.
module csr_access_sequencer
  import csr_access_sequencer_pkg::*;
#(
  parameter int CSR_DATA_WIDTH = 32,
  parameter int CSR_ADDR_WIDTH = 12,
  parameter int BUSY_TIMEOUT   = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      pipe_req_i,
  input  logic [1:0]                pipe_op_i,
  input  logic [CSR_ADDR_WIDTH-1:0] pipe_addr_i,
  input  logic [CSR_DATA_WIDTH-1:0] pipe_wdata_i,
  output logic                      pipe_ack_o,
  output logic [CSR_DATA_WIDTH-1:0] pipe_rdata_o,
  output logic                      pipe_err_o,
  input  logic                      trap_req_i,
  input  logic [CSR_DATA_WIDTH-1:0] trap_epc_i,
  input  logic [CSR_DATA_WIDTH-1:0] trap_cause_i,
  input  logic [CSR_DATA_WIDTH-1:0] trap_tval_i,
  output logic                      trap_done_o,
  output logic [CSR_DATA_WIDTH-1:0] trap_vec_o,
  output logic                      trap_err_o,
  output logic                      csr_en_o,
  output logic [1:0]                csr_op_o,
  output logic [CSR_ADDR_WIDTH-1:0] csr_addr_o,
  output logic [CSR_DATA_WIDTH-1:0] csr_wdata_o,
  input  logic [CSR_DATA_WIDTH-1:0] csr_rdata_i,
  input  logic                      csr_busy_i
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  state_e                    state_q, state_d;
  owner_e                    owner_q, owner_d;
  logic [1:0]                step_q, step_d;
  logic [TW-1:0]             tmo_q, tmo_d;
  logic                      err_q, err_d;
  logic [CSR_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                op_q, op_d;
  logic [CSR_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CSR_DATA_WIDTH-1:0] wdata_q, wdata_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_PIPE;
      step_q  <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      step_q  <= step_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    step_d  = step_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!csr_busy_i && trap_req_i) begin
          owner_d = OWN_TRAP;
          step_d  = '0;
          op_d    = OP_WRITE;
          addr_d  = CSR_ADDR_WIDTH'(ADDR_MEPC);
          wdata_d = trap_epc_i;
          err_d   = 1'b0;
          rdata_d = '0;
          state_d = ST_ISSUE;
        end else if (!csr_busy_i && pipe_req_i) begin
          owner_d = OWN_PIPE;
          op_d    = pipe_op_i;
          addr_d  = pipe_addr_i;
          wdata_d = pipe_wdata_i;
          rdata_d = '0;
          err_d   = pipe_illegal(pipe_op_i, pipe_addr_i[CSR_ADDR_WIDTH-1 -: 2], |pipe_wdata_i);
          state_d = err_d ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tmo_d   = '0;
        state_d = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (csr_busy_i) begin
          rdata_d = csr_rdata_i;
          state_d = ST_WAIT_LO;
        end else if (tmo_q == TW'(BUSY_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = ST_RESP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_WAIT_LO: begin
        if (!csr_busy_i) begin
          if (owner_q == OWN_TRAP && step_q != 2'd3) begin
            step_d  = step_q + 2'd1;
            op_d    = OP_WRITE;
            state_d = ST_ISSUE;
            case (step_d)
              2'd1: begin
                addr_d  = CSR_ADDR_WIDTH'(ADDR_MCAUSE);
                wdata_d = trap_cause_i;
              end
              2'd2: begin
                addr_d  = CSR_ADDR_WIDTH'(ADDR_MTVAL);
                wdata_d = trap_tval_i;
              end
              default: begin
                op_d    = OP_SET;
                addr_d  = CSR_ADDR_WIDTH'(ADDR_MTVEC);
                wdata_d = '0;
              end
            endcase
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Responses are decoded from registered state so reset clears them immediately.
  always_comb begin
    csr_en_o     = (state_q == ST_ISSUE);
    csr_op_o     = op_q;
    csr_addr_o   = addr_q;
    csr_wdata_o  = wdata_q;
    pipe_ack_o   = (state_q == ST_RESP) && (owner_q == OWN_PIPE);
    trap_done_o  = (state_q == ST_RESP) && (owner_q == OWN_TRAP);
    pipe_err_o   = pipe_ack_o && err_q;
    trap_err_o   = trap_done_o && err_q;
    pipe_rdata_o = pipe_ack_o ? rdata_q : '0;
    trap_vec_o   = (trap_done_o && !err_q) ? {rdata_q[CSR_DATA_WIDTH-1:2], 2'b00} : '0;
  end

endmodule

// File: tb/tb_csr_access_sequencer.sv
// Scoreboard bench: a CSR-file responder, a reference model that predicts
// strobes and completions, and a monitor that pops and compares them.
module tb_csr_access_sequencer;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_req_i, pipe_ack_o, pipe_err_o;
  logic [1:0]  pipe_op_i;
  logic [11:0] pipe_addr_i;
  logic [31:0] pipe_wdata_i, pipe_rdata_o;
  logic        trap_req_i, trap_done_o, trap_err_o;
  logic [31:0] trap_epc_i, trap_cause_i, trap_tval_i, trap_vec_o;
  logic        csr_en_o;
  logic [1:0]  csr_op_o;
  logic [11:0] csr_addr_o;
  logic [31:0] csr_wdata_o;
  logic [31:0] csr_rdata_i = '0;
  logic        csr_busy_i = 1'b0;

  always #5 clk = ~clk;

  csr_access_sequencer #(.CSR_DATA_WIDTH(32), .CSR_ADDR_WIDTH(12), .BUSY_TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst),
    .pipe_req_i(pipe_req_i), .pipe_op_i(pipe_op_i), .pipe_addr_i(pipe_addr_i),
    .pipe_wdata_i(pipe_wdata_i), .pipe_ack_o(pipe_ack_o), .pipe_rdata_o(pipe_rdata_o),
    .pipe_err_o(pipe_err_o),
    .trap_req_i(trap_req_i), .trap_epc_i(trap_epc_i), .trap_cause_i(trap_cause_i),
    .trap_tval_i(trap_tval_i), .trap_done_o(trap_done_o), .trap_vec_o(trap_vec_o),
    .trap_err_o(trap_err_o),
    .csr_en_o(csr_en_o), .csr_op_o(csr_op_o), .csr_addr_o(csr_addr_o),
    .csr_wdata_o(csr_wdata_o), .csr_rdata_i(csr_rdata_i), .csr_busy_i(csr_busy_i)
  );

  typedef struct {logic [11:0] addr; logic [1:0] op; logic [31:0] data;} strobe_t;
  typedef struct {bit is_trap; bit err; bit chk; logic [31:0] data;} resp_t;

  strobe_t exp_strobes[$];
  resp_t   exp_resps[$];
  int      errors = 0;
  int      checks = 0;

  logic [31:0] mem[4096];
  logic [31:0] ref_mem[4096];
  bit          stuck_arm = 1'b0;
  int          skip_ok = 0;
  logic [1:0]  bcnt = '0;

  function automatic logic [31:0] apply(logic [1:0] op, logic [31:0] o, logic [31:0] d);
    case (op)
      2'd0:    return o | d;
      2'd1:    return d;
      2'd2:    return o & ~d;
      default: return o;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // CSR file: busy high the two cycles after a strobe, old value on rdata.
  always @(posedge clk) begin
    if (csr_en_o === 1'b1) begin
      if (stuck_arm && skip_ok == 0) begin
        stuck_arm = 1'b0;
      end else begin
        if (stuck_arm) skip_ok--;
        csr_busy_i  <= 1'b1;
        bcnt        <= 2'd1;
        csr_rdata_i <= mem[csr_addr_o];
        mem[csr_addr_o] <= apply(csr_op_o, mem[csr_addr_o], csr_wdata_o);
      end
    end else if (csr_busy_i) begin
      if (bcnt != 0) bcnt <= bcnt - 2'd1;
      else csr_busy_i <= 1'b0;
    end
  end

  strobe_t ms;
  resp_t   mr;

  task automatic take_resp(bit is_trap, logic err, logic [31:0] data);
    if (exp_resps.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_completion: actual trap=%0d err=%0d data=0x%0h required none",
               is_trap, err, data);
    end else begin
      mr = exp_resps.pop_front();
      check("resp_owner_is_trap", 32'(is_trap), 32'(mr.is_trap));
      check("resp_err", 32'(err), 32'(mr.err));
      if (mr.chk) check(is_trap ? "trap_vec" : "pipe_rdata", data, mr.data);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (csr_en_o) begin
        if (exp_strobes.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_strobe: actual addr=0x%0h required none", csr_addr_o);
        end else begin
          ms = exp_strobes.pop_front();
          check("strobe_addr", 32'(csr_addr_o), 32'(ms.addr));
          check("strobe_op", 32'(csr_op_o), 32'(ms.op));
          check("strobe_data", csr_wdata_o, ms.data);
        end
      end
      if (pipe_ack_o) take_resp(1'b0, pipe_err_o, pipe_rdata_o);
      if (trap_done_o) take_resp(1'b1, trap_err_o, trap_vec_o);
    end
  end

  function automatic void push_strobe(logic [11:0] a, logic [1:0] op, logic [31:0] d);
    strobe_t s;
    s.addr = a; s.op = op; s.data = d;
    exp_strobes.push_back(s);
  endfunction

  function automatic void push_resp(bit is_trap, bit err, bit chk, logic [31:0] d);
    resp_t r;
    r.is_trap = is_trap; r.err = err; r.chk = chk; r.data = d;
    exp_resps.push_back(r);
  endfunction

  // Reference model: what the CSR file should see and what the requester gets back.
  function automatic void predict_pipe(logic [1:0] op, logic [11:0] a, logic [31:0] d, bit stuck);
    if (op == 2'd3 || (a[11:10] == 2'b11 && (op != 2'd0 || d != 0))) begin
      push_resp(1'b0, 1'b1, 1'b1, 32'h0);
    end else begin
      push_strobe(a, op, d);
      if (stuck) push_resp(1'b0, 1'b1, 1'b0, 32'h0);
      else begin
        push_resp(1'b0, 1'b0, 1'b1, ref_mem[a]);
        ref_mem[a] = apply(op, ref_mem[a], d);
      end
    end
  endfunction

  function automatic void predict_trap(logic [31:0] epc, logic [31:0] cause, logic [31:0] tval,
                                       int stuck_step);
    logic [11:0] a[4];
    logic [31:0] v[4];
    a[0] = 12'h341; a[1] = 12'h342; a[2] = 12'h343; a[3] = 12'h305;
    v[0] = epc; v[1] = cause; v[2] = tval; v[3] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      push_strobe(a[i], (i == 3) ? 2'd0 : 2'd1, v[i]);
      if (i == stuck_step) begin
        push_resp(1'b1, 1'b1, 1'b1, 32'h0);
        return;
      end
      if (i < 3) ref_mem[a[i]] = v[i];
    end
    push_resp(1'b1, 1'b0, 1'b1, ref_mem[12'h305] & ~32'h3);
  endfunction

  task automatic drive_pipe(logic [1:0] op, logic [11:0] a, logic [31:0] d, output int lat);
    pipe_op_i = op; pipe_addr_i = a; pipe_wdata_i = d; pipe_req_i = 1'b1;
    lat = 0;
    while (!pipe_ack_o && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    if (!pipe_ack_o) begin
      checks++; errors++;
      $display("FAIL pipe_ack_timeout: actual no ack required ack within 300 cycles");
    end
    pipe_req_i = 1'b0;
  endtask

  task automatic drive_trap(logic [31:0] epc, logic [31:0] cause, logic [31:0] tval);
    int n = 0;
    trap_epc_i = epc; trap_cause_i = cause; trap_tval_i = tval; trap_req_i = 1'b1;
    while (!trap_done_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!trap_done_o) begin
      checks++; errors++;
      $display("FAIL trap_done_timeout: actual no done required done within 300 cycles");
    end
    trap_req_i = 1'b0;
  endtask

  task automatic check_quiet(string tag);
    check({tag, "_csr_en"}, 32'(csr_en_o), 0);
    check({tag, "_csr_addr"}, 32'(csr_addr_o), 0);
    check({tag, "_csr_op"}, 32'(csr_op_o), 0);
    check({tag, "_csr_wdata"}, csr_wdata_o, 0);
    check({tag, "_acks"}, {30'h0, pipe_ack_o, trap_done_o}, 0);
    check({tag, "_errs"}, {30'h0, pipe_err_o, trap_err_o}, 0);
    check({tag, "_rdata"}, pipe_rdata_o | trap_vec_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual simulation still running required finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    logic [11:0] alist[6];
    logic [11:0] a;
    logic [1:0]  op;
    logic [31:0] d, e, c, t;
    bit          stuck;
    int          s;
    alist[0] = 12'h340; alist[1] = 12'h300; alist[2] = 12'hF14;
    alist[3] = 12'hC00; alist[4] = 12'h305; alist[5] = 12'h341;
    pipe_req_i = 0; pipe_op_i = 0; pipe_addr_i = 0; pipe_wdata_i = 0;
    trap_req_i = 0; trap_epc_i = 0; trap_cause_i = 0; trap_tval_i = 0;
    for (int i = 0; i < 4096; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    rst = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst = 1'b0;
    @(negedge clk);

    // Legal write, minimum latency.
    mem[12'h340] = 32'h1; ref_mem[12'h340] = 32'h1;
    predict_pipe(2'd1, 12'h340, 32'hDEADBEEF, 1'b0);
    drive_pipe(2'd1, 12'h340, 32'hDEADBEEF, lat);
    check("pipe_latency", 32'(lat), 5);
    @(negedge clk);

    // Write to a read-only CSR is rejected with no strobe; a pure read is legal.
    predict_pipe(2'd1, 12'hF14, 32'h5, 1'b0);
    drive_pipe(2'd1, 12'hF14, 32'h5, lat);
    check("illegal_latency", 32'(lat), 1);
    @(negedge clk);
    predict_pipe(2'd0, 12'hF14, 32'h0, 1'b0);
    drive_pipe(2'd0, 12'hF14, 32'h0, lat);
    @(negedge clk);

    // Trap entry sequence.
    mem[12'h305] = 32'h203; ref_mem[12'h305] = 32'h203;
    predict_trap(32'h100, 32'h2, 32'h0, 4);
    drive_trap(32'h100, 32'h2, 32'h0);
    @(negedge clk);

    // Same-cycle trap and pipe: trap served first.
    predict_trap(32'h2000, 32'hB, 32'h77, 4);
    predict_pipe(2'd2, 12'h340, 32'hF0, 1'b0);
    fork
      drive_trap(32'h2000, 32'hB, 32'h77);
      drive_pipe(2'd2, 12'h340, 32'hF0, lat);
    join
    @(negedge clk);

    // Busy never rises: pipe waits TMO cycles in WAIT_HI after ISSUE.
    stuck_arm = 1'b1; skip_ok = 0;
    predict_pipe(2'd1, 12'h300, 32'h1234, 1'b1);
    drive_pipe(2'd1, 12'h300, 32'h1234, lat);
    check("pipe_timeout_latency", 32'(lat), TMO + 2);
    stuck_arm = 1'b0;
    @(negedge clk);

    // Trap times out on step 1; steps 2 and 3 must not be issued.
    stuck_arm = 1'b1; skip_ok = 1;
    predict_trap(32'h400, 32'h5, 32'h9, 1);
    drive_trap(32'h400, 32'h5, 32'h9);
    stuck_arm = 1'b0;
    @(negedge clk);

    // Reset while in WAIT_LO abandons the transaction silently.
    predict_pipe(2'd1, 12'h300, 32'hCAFE0001, 1'b0);
    pipe_op_i = 2'd1; pipe_addr_i = 12'h300; pipe_wdata_i = 32'hCAFE0001; pipe_req_i = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_quiet("async_reset");
    exp_resps.delete();
    pipe_req_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    predict_pipe(2'd0, 12'h300, 32'h0, 1'b0);
    drive_pipe(2'd0, 12'h300, 32'h0, lat);
    @(negedge clk);

    // Randomized mix.
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      stuck = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) begin
        e = $urandom; c = $urandom; t = $urandom;
        s = stuck ? int'($urandom_range(0, 3)) : 4;
        if (stuck) begin stuck_arm = 1'b1; skip_ok = s; end
        predict_trap(e, c, t, s);
        drive_trap(e, c, t);
      end else begin
        a  = alist[$urandom_range(0, 5)];
        op = 2'($urandom_range(0, 3));
        d  = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
        if (stuck) begin stuck_arm = 1'b1; skip_ok = 0; end
        predict_pipe(op, a, d, stuck);
        drive_pipe(op, a, d, lat);
      end
      stuck_arm = 1'b0;
      @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("leftover_strobes", 32'(exp_strobes.size()), 0);
    check("leftover_resps", 32'(exp_resps.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
